// File: rtl/gpu_sched_pkg.sv
// Shared types and default sizes for the warp scheduler and its neighbours.
package gpu_sched_pkg;

    typedef enum logic [1:0] {
        T_READY,
        T_WAIT,
        T_DONE
    } thread_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } sched_state_e;

    localparam int NUM_THREADS_DEF = 16;
    localparam int TID_W_DEF       = 5;
    localparam int WB_LAT_DEF      = 3;

endpackage

// File: rtl/warp_scheduler_if.sv
// Pipeline-side bundle of the warp scheduler: issue handshake, writeback slot,
// thread events and a debug view of the scheduler FSM.
interface warp_scheduler_if
    import gpu_sched_pkg::*;
#(
    parameter int TID_W = TID_W_DEF
);
    // issue_valid/issue_thread stay stable until issue_valid && issue_ready;
    // the transfer happens on the clock edge where both are high.
    logic             issue_valid;
    logic             issue_ready;
    logic [TID_W-1:0] issue_thread;
    logic [31:0]      bidx;
    logic             wb_valid;
    logic [TID_W-1:0] wb_thread;
    logic             stall_valid;
    logic [TID_W-1:0] stall_thread;
    logic             wake_valid;
    logic [TID_W-1:0] wake_thread;
    logic             exit_valid;
    logic [TID_W-1:0] exit_thread;
    sched_state_e     state;

    modport master (
        output issue_valid, issue_thread, bidx, wb_valid, wb_thread, state,
        input  issue_ready, stall_valid, stall_thread, wake_valid, wake_thread,
               exit_valid, exit_thread
    );

    modport slave (
        input  issue_valid, issue_thread, bidx, wb_valid, wb_thread, state,
        output issue_ready, stall_valid, stall_thread, wake_valid, wake_thread,
               exit_valid, exit_thread
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational circular first-set finder: searches req from ptr+1 upward,
// wrapping, and ends on ptr itself so a lone requester is picked again.
module rr_picker #(
    parameter int N  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    int            cand;
    logic [SW-1:0] sel;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            sel  = SW'(cand);
            if (!found && req[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin thread issue with per-thread READY/WAIT/DONE tracking and a
// writeback-aligned copy of every accepted thread id.
module warp_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int TID_W       = TID_W_DEF,
    parameter int WB_LAT      = WB_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  thread_count,
    input  logic [31:0] block_idx,
    output logic        busy,
    output logic        done,
    warp_scheduler_if.master sif
);

    localparam int SW = $clog2(NUM_THREADS);

    sched_state_e     state, state_n;
    thread_state_e    tstate   [NUM_THREADS];
    thread_state_e    tstate_n [NUM_THREADS];
    logic [NUM_THREADS-1:0] ready_mask;
    logic [SW-1:0]    rr_ptr, pick_ptr, pick_idx;
    logic             pick_found, accept, hold, all_done, line_busy;
    logic             wb_v [WB_LAT];
    logic [TID_W-1:0] wb_t [WB_LAT];
    int               launch_n;

    assign accept   = sif.issue_valid && sif.issue_ready;
    assign hold     = sif.issue_valid && !sif.issue_ready;
    assign pick_ptr = accept ? sif.issue_thread[SW-1:0] : rr_ptr;
    assign launch_n = (int'(thread_count) > NUM_THREADS) ? NUM_THREADS : int'(thread_count);

    // Selection looks at the post-event states so an event lands on the very next issue.
    always_comb begin
        ready_mask = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            tstate_n[i] = tstate[i];
            if (state == S_IDLE) begin
                if (start) tstate_n[i] = (i < launch_n) ? T_READY : T_DONE;
            end else if (sif.exit_valid && sif.exit_thread == TID_W'(i)) begin
                tstate_n[i] = T_DONE;
            end else if (sif.stall_valid && sif.stall_thread == TID_W'(i)) begin
                if (tstate[i] == T_READY) tstate_n[i] = T_WAIT;
            end else if (sif.wake_valid && sif.wake_thread == TID_W'(i)) begin
                if (tstate[i] == T_WAIT) tstate_n[i] = T_READY;
            end
            ready_mask[i] = (tstate_n[i] == T_READY);
        end
    end

    always_comb begin
        all_done  = 1'b1;
        line_busy = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) all_done = all_done && (tstate[i] == T_DONE);
        for (int k = 0; k < WB_LAT; k++) line_busy = line_busy || wb_v[k];
    end

    rr_picker #(.N(NUM_THREADS), .SW(SW)) u_pick (
        .req   (ready_mask),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = (thread_count == 5'd0) ? S_DRAIN : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (all_done && !sif.issue_valid) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!line_busy) state_n = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) tstate[i] <= T_DONE;
            rr_ptr           <= SW'(NUM_THREADS - 1);
            sif.issue_valid  <= 1'b0;
            sif.issue_thread <= '0;
            sif.bidx         <= '0;
            for (int k = 0; k < WB_LAT; k++) begin
                wb_v[k] <= 1'b0;
                wb_t[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) tstate[i] <= tstate_n[i];
            if (state == S_IDLE && start) begin
                sif.bidx <= block_idx;
                rr_ptr   <= SW'(NUM_THREADS - 1);
            end else if (accept) begin
                rr_ptr <= sif.issue_thread[SW-1:0];
            end
            if (!hold) begin
                sif.issue_valid <= (state == S_RUN) && pick_found;
                if (pick_found) sif.issue_thread <= TID_W'(pick_idx);
            end
            wb_v[0] <= accept;
            wb_t[0] <= accept ? sif.issue_thread : '0;
            for (int k = 1; k < WB_LAT; k++) begin
                wb_v[k] <= wb_v[k-1];
                wb_t[k] <= wb_t[k-1];
            end
        end
    end

    assign sif.wb_valid  = wb_v[WB_LAT-1];
    assign sif.wb_thread = wb_t[WB_LAT-1];
    assign sif.state     = state;

endmodule
